regfile: RTL and testbench

//   Architectural integer register file; responder for the regrd read-request interface.

---
 rtl/regfile.sv | 74 +++++++
 tb/tb_regfile.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Architectural integer register file: NUM_RD_PORTS registered read ports, one write port, x0 reads as zero.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile #(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NUM_RD_PORTS = 2,
  localparam int unsigned AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_RD_PORTS-1:0]              rdens_rd0,
  input  logic [NUM_RD_PORTS-1:0][AW-1:0]      rdaddrs_rd0,
  output logic [NUM_RD_PORTS-1:0][XLEN-1:0]    rddatas_rd1,
  input  logic                                 wren_rb1,
  input  logic [AW-1:0]                        wraddr_rb1,
  input  logic [XLEN-1:0]                      wrdata_rb1
);

  logic [NUM_REGS-1:0][XLEN-1:0] mem;
  logic                          wr_ok;

  // Nonzero and in range: entry 0 and out-of-range addresses are never stored
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < NUM_REGS);
  endfunction

  always_comb begin
    wr_ok = wren_rb1 && addr_ok(wraddr_rb1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else if (wr_ok) begin
      mem[wraddr_rb1] <= wrdata_rb1;
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [XLEN-1:0] rd_val;

    always_comb begin
      rd_val = '0;
      if (addr_ok(rdaddrs_rd0[p])) begin
        rd_val = mem[rdaddrs_rd0[p]];
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wraddr_rb1 == rdaddrs_rd0[p])) begin
        rd_val = wrdata_rb1;
      end
`endif
    end

    // Output holds when the port is idle so a stalled consumer sees stable data
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rddatas_rd1[p] <= '0;
      end else if (rdens_rd0[p]) begin
        rddatas_rd1[p] <= rd_val;
      end
    end

`ifndef REGFILE_BYPASS_EN
`ifdef SIMULATION
    always_ff @(posedge clk) begin
      if (!reset && rdens_rd0[p] && wr_ok && (wraddr_rb1 == rdaddrs_rd0[p])) begin
        $display("INFO regfile: port %0d read/write collision on x%0d at %0t", p, rdaddrs_rd0[p], $time);
      end
    end
`endif
`endif
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed cases with literal expectations plus randomized traffic
// checked every cycle against an array-based model of the register file.
module tb_regfile;
  localparam int unsigned NR = 32;
  localparam int unsigned XL = 32;
  localparam int unsigned NP = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NP-1:0]           rdens;
  logic [NP-1:0][4:0]      rdaddrs;
  logic [NP-1:0][XL-1:0]   rddatas;
  logic                    wren;
  logic [4:0]              wraddr;
  logic [XL-1:0]           wrdata;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [XL-1:0] model_regs [NR];
  logic [XL-1:0] exp_rd [NP];

  regfile #(.NUM_REGS(NR), .XLEN(XL), .NUM_RD_PORTS(NP)) dut (
    .clk        (clk),
    .reset      (reset),
    .rdens_rd0  (rdens),
    .rdaddrs_rd0(rdaddrs),
    .rddatas_rd1(rddatas),
    .wren_rb1   (wren),
    .wraddr_rb1 (wraddr),
    .wrdata_rb1 (wrdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: read returns the register value before this cycle's write
  // (or the written value when forwarding is enabled); x0 is always zero.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) model_regs[i] = '0;
      for (int p = 0; p < NP; p++) exp_rd[p] = '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (rdens[p]) begin
          if (rdaddrs[p] == 5'd0) exp_rd[p] = '0;
          else if (BYPASS && wren && wraddr == rdaddrs[p]) exp_rd[p] = wrdata;
          else exp_rd[p] = model_regs[rdaddrs[p]];
        end
      end
      if (wren && wraddr != 5'd0) model_regs[wraddr] = wrdata;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NP; p++) chk($sformatf("model_rd%0d", p), rddatas[p], exp_rd[p]);
    end
  end

  task automatic idle();
    rdens = '0; rdaddrs = '0; wren = 1'b0; wraddr = '0; wrdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [XL-1:0] d);
    wren = 1'b1; wraddr = a; wrdata = d;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    rdens[p] = 1'b1; rdaddrs[p] = a;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_rd0", rddatas[0], 32'h0);
    chk("reset_rd1", rddatas[1], 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Read after reset returns zero
    idle(); rd(0, 5'd5); rd(1, 5'd7); tick();
    chk("t1_rd0", rddatas[0], 32'h0);
    chk("t1_rd1", rddatas[1], 32'h0);

    // Write then read on both ports
    idle(); wr(5'd5, 32'hDEAD_BEEF); tick();
    idle(); rd(0, 5'd5); rd(1, 5'd5); tick();
    chk("t2_rd0", rddatas[0], 32'hDEAD_BEEF);
    chk("t2_rd1", rddatas[1], 32'hDEAD_BEEF);

    // x0 stays zero
    idle(); wr(5'd0, 32'h1234); tick();
    idle(); rd(0, 5'd0); tick();
    chk("t3_x0", rddatas[0], 32'h0);
    idle(); wr(5'd0, 32'h1234); rd(0, 5'd0); rd(1, 5'd0); tick();
    chk("t3_x0_same0", rddatas[0], 32'h0);
    chk("t3_x0_same1", rddatas[1], 32'h0);

    // Same-cycle write/read collision
    idle(); wr(5'd9, 32'h11); tick();
    idle(); wr(5'd9, 32'h22); rd(0, 5'd9); tick();
    chk("t4_collide", rddatas[0], BYPASS ? 32'h22 : 32'h11);
    idle(); rd(0, 5'd9); tick();
    chk("t4_after", rddatas[0], 32'h22);

    // Hold while idle
    idle(); rd(0, 5'd5); tick();
    chk("t5_read", rddatas[0], 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      idle(); wr(5'd5, 32'h0); tick();
      chk($sformatf("t5_hold%0d", i), rddatas[0], 32'hDEAD_BEEF);
    end

    // Asynchronous reset mid-cycle; write during reset is dropped
    idle(); wr(5'd3, 32'hAA); tick();
    idle(); rd(0, 5'd3); rd(1, 5'd5); tick();
    chk("t6_pre", rddatas[0], 32'hAA);
    #2 reset = 1'b1;
    #1;
    chk("t6_async0", rddatas[0], 32'h0);
    chk("t6_async1", rddatas[1], 32'h0);
    idle(); wr(5'd3, 32'h55);
    @(negedge clk);
    reset = 1'b0;
    idle(); rd(0, 5'd3); rd(1, 5'd9); tick();
    chk("t6_x3", rddatas[0], 32'h0);
    chk("t6_x9", rddatas[1], 32'h0);

    // Randomized traffic, biased to small addresses for collisions
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        rdens[p] = ($urandom_range(0, 3) != 0);
        rdaddrs[p] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      end
      wren = ($urandom_range(0, 1) != 0);
      wraddr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wrdata = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    idle();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
